// File: rtl/io_prog_loader_pkg.sv
// io_prog_loader_pkg
// Shared definitions for the serial program loader: loader FSM state type,
// instruction word width and default instruction-memory address width.
package io_prog_loader_pkg;

    localparam int INSTR_W    = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage : io_prog_loader_pkg

// File: rtl/io_prog_loader_pin_sync.sv
// pin_sync
// Multi-flop synchronizer for one asynchronous input pin.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears every stage
//   d    - asynchronous pin
//   q    - synchronized copy, STAGES cycles behind d
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : pin_sync

// File: rtl/io_prog_loader.sv
// io_prog_loader
// Loads a program into the core's instruction memory from an external host
// over a three-pin serial link (mode / bit clock / data, MSB first) while
// holding the core in reset.
// Ports:
//   wb_clk_i, wb_rst_i  - clock, asynchronous active-high reset
//   ld_mode_i           - session request pin (async)
//   ld_sclk_i           - serial bit clock pin (async)
//   ld_sdata_i          - serial data pin (async)
//   imem_we_o           - one-cycle instruction memory write strobe
//   imem_addr_o         - write address / words written this session
//   imem_wdata_o        - last fully assembled instruction word
//   cpu_rst_o           - core reset, high for the whole session
//   ld_done_o           - one-cycle pulse at session end
//   ld_ovf_o            - sticky: last address of the memory was written
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no session; core released; waits for armed mode request
// ST_SHIFT | collecting serial bits into the shift register
// ST_WRITE | one-cycle write of the completed word; still shifting
// ST_DONE  | one-cycle end-of-session pulse, core still in reset
module io_prog_loader
    import io_prog_loader_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               ld_mode_i,
    input  logic               ld_sclk_i,
    input  logic               ld_sdata_i,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               cpu_rst_o,
    output logic               ld_done_o,
    output logic               ld_ovf_o
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic mode_s;
    logic sclk_s;
    logic sdata_s;

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mode (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (ld_mode_i),
        .q   (mode_s)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (ld_sclk_i),
        .q   (sclk_s)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (ld_sdata_i),
        .q   (sdata_s)
    );

    ld_state_e          state_q,     state_d;
    logic               sclk_prev_q, sclk_prev_d;
    logic [INSTR_W-1:0] shreg_q,     shreg_d;
    logic [3:0]         bitcnt_q,    bitcnt_d;
    logic [INSTR_W-1:0] wdata_q,     wdata_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic               ovf_q,       ovf_d;
    // Armed once mode has been seen low, so a mode level left high after a
    // session cannot immediately start another one.
    logic               armed_q,     armed_d;

    logic sclk_rise;
    logic shift_en;

    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        state_d     = state_q;
        sclk_prev_d = sclk_s;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q;
        armed_d     = armed_q | ~mode_s;
        shift_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mode_s && armed_q) begin
                    state_d  = ST_SHIFT;
                    addr_d   = '0;
                    bitcnt_d = '0;
                    ovf_d    = 1'b0;
                    armed_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                // A word completing in the same cycle mode drops is still written.
                if (sclk_rise && (bitcnt_q == 4'hF)) begin
                    state_d = ST_WRITE;
                end else if (!mode_s) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                // A bit arriving during the write belongs to the next word.
                shift_en = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                if (addr_q == ADDR_LAST) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!mode_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_en && sclk_rise) begin
            shreg_d  = {shreg_q[INSTR_W-2:0], sdata_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'hF) begin
                wdata_d = {shreg_q[INSTR_W-2:0], sdata_s};
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            armed_q     <= armed_d;
        end
    end

    assign imem_we_o    = (state_q == ST_WRITE);
    assign cpu_rst_o    = (state_q != ST_IDLE);
    assign ld_done_o    = (state_q == ST_DONE);
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign ld_ovf_o     = ovf_q;

endmodule : io_prog_loader

// File: tb/tb_io_prog_loader.sv
// Testbench for io_prog_loader. Two instances share the pins: one with the
// default 8-bit address, one with a 2-bit address so overflow is reachable.
module tb_io_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode = 1'b0;
    logic sclk = 1'b0;
    logic sdata = 1'b0;

    logic        we_a, cpu_rst_a, done_a, ovf_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic        we_b, cpu_rst_b, done_b, ovf_b;
    logic [1:0]  addr_b;
    logic [15:0] wdata_b;

    always #5 clk = ~clk;

    io_prog_loader #(.ADDR_W(8), .SYNC_STAGES(2)) dut_a (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .ld_mode_i    (mode),
        .ld_sclk_i    (sclk),
        .ld_sdata_i   (sdata),
        .imem_we_o    (we_a),
        .imem_addr_o  (addr_a),
        .imem_wdata_o (wdata_a),
        .cpu_rst_o    (cpu_rst_a),
        .ld_done_o    (done_a),
        .ld_ovf_o     (ovf_a)
    );

    io_prog_loader #(.ADDR_W(2), .SYNC_STAGES(2)) dut_b (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .ld_mode_i    (mode),
        .ld_sclk_i    (sclk),
        .ld_sdata_i   (sdata),
        .imem_we_o    (we_b),
        .imem_addr_o  (addr_b),
        .imem_wdata_o (wdata_b),
        .cpu_rst_o    (cpu_rst_b),
        .ld_done_o    (done_b),
        .ld_ovf_o     (ovf_b)
    );

    typedef struct {
        int              n;       // full words sent
        int              p;       // trailing partial bits before mode drop
        bit              co;      // mode drop coincides with last bit's sclk rise
        logic [5:0][15:0] w;
        int              exp_wr_a;
        int              exp_addr_a;
        int              exp_wr_b;
        int              exp_addr_b;
        bit              exp_ovf_b;
    } sess_t;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int  done_cnt_a = 0;
    int  done_cnt_b = 0;
    int  low_cnt    = 0;
    bit  sess_active = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) qa.push_back({8'h00, addr_a, wdata_a});
            if (we_b) qb.push_back({14'h0, addr_b, wdata_b});
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
            if (sess_active && !cpu_rst_a) low_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit drop);
        sdata = b;
        tick(6);
        sclk = 1'b1;
        if (drop) begin
            mode = 1'b0;
            sess_active = 1'b0;
        end
        tick(6);
        sclk = 1'b0;
    endtask

    task automatic check_run(input int words_done);
        check("cpu_rst_a_run", {31'b0, cpu_rst_a}, 32'd1);
        check("cpu_rst_b_run", {31'b0, cpu_rst_b}, (words_done < 4) ? 32'd1 : 32'd0);
    endtask

    // Reference model: every complete word is written in order from address 0;
    // a memory of depth D accepts only the first D words then ends the session.
    function automatic sess_t model(input sess_t s);
        sess_t r = s;
        r.exp_wr_a   = s.n;
        r.exp_addr_a = s.n;
        r.exp_wr_b   = (s.n < 4) ? s.n : 4;
        r.exp_addr_b = (s.n >= 4) ? 0 : s.n;
        r.exp_ovf_b  = (s.n >= 4);
        return r;
    endfunction

    task automatic run_session(input sess_t s);
        logic [15:0] pw;
        qa.delete();
        qb.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
        low_cnt    = 0;
        mode = 1'b1;
        tick(6);
        sess_active = 1'b1;
        for (int i = 0; i < s.n; i++) begin
            for (int b = 15; b >= 0; b--) begin
                if (s.co && i == s.n - 1 && b == 0) begin
                    check_run(s.n - 1);
                    send_bit(s.w[i][b], 1'b1);
                end else begin
                    send_bit(s.w[i][b], 1'b0);
                end
            end
        end
        if (!s.co) begin
            pw = 16'($urandom);
            for (int b = 0; b < s.p; b++) send_bit(pw[15-b], 1'b0);
            check_run(s.n);
            sess_active = 1'b0;
            mode = 1'b0;
        end
        tick(12);
        check("wr_cnt_a", qa.size(), s.exp_wr_a);
        for (int i = 0; i < qa.size() && i < s.exp_wr_a; i++)
            check("wr_a", qa[i], {i[15:0], s.w[i]});
        check("wr_cnt_b", qb.size(), s.exp_wr_b);
        for (int i = 0; i < qb.size() && i < s.exp_wr_b; i++)
            check("wr_b", qb[i], {i[15:0], s.w[i]});
        check("addr_a", {24'b0, addr_a}, s.exp_addr_a);
        check("ovf_a", {31'b0, ovf_a}, 32'd0);
        check("addr_b", {30'b0, addr_b}, s.exp_addr_b);
        check("ovf_b", {31'b0, ovf_b}, {31'b0, s.exp_ovf_b});
        check("done_cnt_a", done_cnt_a, 32'd1);
        check("done_cnt_b", done_cnt_b, 32'd1);
        check("cpu_rst_a_end", {31'b0, cpu_rst_a}, 32'd0);
        check("cpu_rst_b_end", {31'b0, cpu_rst_b}, 32'd0);
        check("cpu_rst_a_dropouts", low_cnt, 32'd0);
    endtask

    function automatic sess_t mk(input int n, input int p, input bit co,
                                 input int wa, input int aa, input int wb,
                                 input int ab, input bit ob);
        sess_t s;
        s.n = n; s.p = p; s.co = co;
        for (int i = 0; i < 6; i++) s.w[i] = 16'($urandom);
        s.exp_wr_a = wa; s.exp_addr_a = aa;
        s.exp_wr_b = wb; s.exp_addr_b = ab; s.exp_ovf_b = ob;
        return s;
    endfunction

    sess_t tbl[6];

    initial begin
        sess_t s;
        tbl[0] = mk(2, 0, 1'b0, 2, 2, 2, 2, 1'b0);
        tbl[0].w[0] = 16'hA5C3;
        tbl[0].w[1] = 16'h1234;
        tbl[1] = mk(1, 7, 1'b0, 1, 1, 1, 1, 1'b0);
        tbl[2] = mk(1, 0, 1'b1, 1, 1, 1, 1, 1'b0);
        tbl[3] = mk(5, 0, 1'b0, 5, 5, 4, 0, 1'b1);
        for (int i = 0; i < 5; i++) tbl[3].w[i] = 16'(i + 1);
        tbl[4] = mk(0, 3, 1'b0, 0, 0, 0, 0, 1'b0);
        tbl[5] = mk(4, 9, 1'b0, 4, 4, 4, 0, 1'b1);

        #1 rst = 1'b1;
        tick(1);
        check("rst_we_a", {31'b0, we_a}, 32'd0);
        check("rst_cpu_rst_a", {31'b0, cpu_rst_a}, 32'd0);
        check("rst_addr_a", {24'b0, addr_a}, 32'd0);
        check("rst_wdata_a", {16'b0, wdata_a}, 32'd0);
        check("rst_done_a", {31'b0, done_a}, 32'd0);
        check("rst_ovf_a", {31'b0, ovf_a}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 6; i++) run_session(tbl[i]);

        for (int r = 0; r < 8; r++) begin
            s = mk(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), 1'b0, 0, 0, 0, 0, 1'b0);
            if (s.n > 0 && s.p == 0) s.co = 1'($urandom_range(0, 1));
            run_session(model(s));
        end

        // Reset in the middle of the second word.
        qa.delete();
        qb.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
        s = mk(1, 0, 1'b0, 0, 0, 0, 0, 1'b0);
        mode = 1'b1;
        tick(6);
        for (int b = 15; b >= 0; b--) send_bit(s.w[0][b], 1'b0);
        for (int b = 0; b < 7; b++) send_bit(1'($urandom), 1'b0);
        sdata = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("mid_rst_we_a", {31'b0, we_a}, 32'd0);
        check("mid_rst_cpu_rst_a", {31'b0, cpu_rst_a}, 32'd0);
        check("mid_rst_addr_a", {24'b0, addr_a}, 32'd0);
        check("mid_rst_wdata_a", {16'b0, wdata_a}, 32'd0);
        check("mid_rst_cpu_rst_b", {31'b0, cpu_rst_b}, 32'd0);
        check("mid_rst_ovf_b", {31'b0, ovf_b}, 32'd0);
        tick(2);
        rst = 1'b0;
        check("mid_rst_wr_cnt_a", qa.size(), 32'd1);
        if (qa.size() > 0) check("mid_rst_wr_a", qa[0], {16'h0000, s.w[0]});
        check("mid_rst_no_done_a", done_cnt_a, 32'd0);
        check("mid_rst_no_done_b", done_cnt_b, 32'd0);
        // Mode is still high; the reset armed the loader, so this restarts at 0.
        run_session(model(mk(2, 0, 1'b0, 0, 0, 0, 0, 1'b0)));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_io_prog_loader

// File: doc/io_prog_loader.md
IO_PROG_LOADER -- requirements
Module: io_prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory address width (depth 2^ADDR_W words).
REQ-002 Parameter: SYNC_STAGES, default 2, flip-flop depth of each pin synchronizer (minimum 2).
REQ-003 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-004 wb_rst_i  input  1  asynchronous, active-high reset.
REQ-005 ld_mode_i  input  1  io_in pin, asynchronous; high = program-load session requested.
REQ-006 ld_sclk_i  input  1  io_in pin, asynchronous serial bit clock from the external host.
REQ-007 ld_sdata_i  input  1  io_in pin, asynchronous serial data, MSB first.
REQ-008 imem_we_o  output  1  single-cycle write strobe to processor instruction memory.
REQ-009 imem_addr_o  output  ADDR_W  write address; also the count of words written this session.
REQ-010 imem_wdata_o  output  16  assembled instruction word.
REQ-011 cpu_rst_o  output  1  holds the 16-bit pipelined core in reset while loading.
REQ-012 ld_done_o  output  1  one-cycle pulse at session end.
REQ-013 ld_ovf_o  output  1  sticky flag: session wrote address 2^ADDR_W-1.

Function
REQ-014 Each of ld_mode_i, ld_sclk_i, ld_sdata_i SHALL pass through its own SYNC_STAGES synchronizer before any use.
REQ-015 Sclk rise = synced sclk 1 now, 0 previous cycle; a bit is sampled only on a sclk rise, from synced sdata in that same cycle.
REQ-016 FSM states: IDLE, SHIFT, WRITE, DONE; encoding free.
REQ-017 IDLE: cpu_rst_o=0, imem_we_o=0; synced ld_mode high -> SHIFT, imem_addr_o:=0, bit count:=0, ld_ovf_o:=0.
REQ-018 SHIFT and WRITE: cpu_rst_o=1; every sclk rise shifts one bit into LSB of a 16-bit shift register and increments a 4-bit bit counter.
REQ-019 Sclk rise that completes the 16th bit (counter 15->0) -> WRITE next cycle; imem_wdata_o shows the full word from that cycle on.
REQ-020 WRITE lasts exactly one cycle with imem_we_o=1; imem_addr_o increments the cycle after WRITE.
REQ-021 WRITE at address 2^ADDR_W-1: set ld_ovf_o, address wraps to 0, next state DONE.
REQ-022 Sclk rise in WRITE cycle is accepted as bit 15 of the next word; no bit lost.
REQ-023 Synced ld_mode low in SHIFT -> DONE; partial word (bit count non-zero) discarded, not written.
REQ-024 Synced ld_mode low in WRITE: write still completes, then DONE.
REQ-025 DONE: one cycle, ld_done_o=1, cpu_rst_o=1, -> IDLE; cpu_rst_o falls on entry to IDLE.
REQ-026 IDLE entered from DONE with synced ld_mode still high SHALL NOT start a new session until ld_mode seen low at least one cycle.
REQ-027 Latency pin sclk edge to shift: SYNC_STAGES+1 cycles; external sclk high and low phases each >= SYNC_STAGES+2 wb_clk_i periods.
REQ-028 imem_addr_o, ld_ovf_o hold their values in IDLE until the next session starts.

Reset
REQ-029 wb_rst_i high: asynchronously state:=IDLE; all outputs, synchronizers, shift register, bit counter, address:=0; session-arm latch treats ld_mode as low-seen.
REQ-030 Reset mid-session: no further imem_we_o; cpu_rst_o=0 immediately; no ld_done_o pulse.

Structure
REQ-031 Shared package holds the FSM state enum, instruction width constant (16) and default ADDR_W.
REQ-032 One sub-module, pin_sync (SYNC_STAGES-deep, 1-bit), instantiated three times.
REQ-033 Instantiated in the user project beside the core; ld_* from io_in pins, corresponding io_oeb driven high by the integration level.

Verification
REQ-034 Session with words 16'hA5C3, 16'h1234, mode drop -> two writes addr 0/1 with those data, ld_done_o one pulse, cpu_rst_o high throughout then 0, ld_ovf_o=0.
REQ-035 Mode drop after 7 bits of word 2 -> only addr 0 written, ld_done_o pulses, imem_addr_o=1.
REQ-036 ADDR_W=2, five words 16'h0001..16'h0005 -> writes at 0,1,2,3 then ld_ovf_o=1, DONE; fifth word never written.
REQ-037 Mode low coinciding with 16th sclk rise -> word written, then ld_done_o.
REQ-038 wb_rst_i pulse mid-word 2 -> imem_we_o stays 0, outputs 0 asynchronously, new session restarts at addr 0.
REQ-039 Mode held high after DONE -> no new session until mode low >= 1 cycle then high again.
